// File: rtl/dlx_fetch_unit.sv
// dlx_fetch_unit: DLX PC register, request/ack instruction fetch and next-PC selection.
// Define FETCH_MISALIGN_TRAP_EN to trap misaligned redirects instead of masking them.
module dlx_fetch_unit #(
    parameter logic [0:31] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [0:31] imem_addr,
    input  logic        imem_ack,
    input  logic [0:31] imem_rdata,
    output logic [0:31] inst,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [0:31] pc_out,
    output logic [0:31] link_addr,
    input  logic        jump,
    input  logic        branch,
    input  logic        branchZero,
    input  logic        regToPC,
    input  logic [0:31] reg_a,
    output logic        fault
);
    typedef enum logic [1:0] {
        IDLE,
        REQ,
        HOLD
`ifdef FETCH_MISALIGN_TRAP_EN
        , FAULT
`endif
    } state_t;

    state_t      state;
    logic [0:31] pc, link, next_raw, next_pc;
    logic        taken;

    assign taken    = branchZero ? (reg_a == 32'd0) : (reg_a != 32'd0);
    assign next_raw = jump ? (regToPC ? reg_a : link + {{6{inst[6]}}, inst[6:31]})
                    : (branch && taken) ? link + {{16{inst[16]}}, inst[16:31]}
                    : link;

`ifdef FETCH_MISALIGN_TRAP_EN
    assign next_pc = next_raw;
    assign fault   = (state == FAULT);
`else
    assign next_pc = {next_raw[0:29], 2'b00};
    assign fault   = 1'b0;
`endif

    assign imem_req   = (state == REQ);
    assign inst_valid = (state == HOLD);
    assign imem_addr  = pc;
    assign pc_out     = pc;
    assign link_addr  = link;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            pc    <= RESET_PC;
            link  <= RESET_PC + 32'd4;
            inst  <= 32'd0;
        end else begin
            case (state)
                IDLE: state <= REQ;
                REQ: begin
                    if (imem_ack) begin
                        inst  <= imem_rdata;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (inst_ready) begin
                        pc   <= next_pc;
                        link <= next_pc + 32'd4;
`ifdef FETCH_MISALIGN_TRAP_EN
                        state <= (next_pc[30:31] != 2'b00) ? FAULT : REQ;
`else
                        state <= REQ;
`endif
                    end
                end
                default: state <= state;
            endcase
        end
    end
endmodule

// File: tb/tb_dlx_fetch_unit.sv
// tb_dlx_fetch_unit: directed checks of fetch handshake, next-PC selection and backpressure.
module tb_dlx_fetch_unit;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [0:31] imem_addr, imem_rdata = 32'd0;
    logic [0:31] inst, pc_out, link_addr;
    logic        inst_valid, inst_ready = 1'b0;
    logic        jump = 1'b0, branch = 1'b0, branchZero = 1'b0, regToPC = 1'b0;
    logic [0:31] reg_a = 32'd0;
    logic        fault;
    int          checks = 0, errors = 0;

    localparam logic [0:31] B_WORD = 32'h1000_FFF8;
    localparam logic [0:31] J_WORD = 32'h0BFF_FFF8;

    dlx_fetch_unit #(.RESET_PC(32'h0000_0100)) dut (
        .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .pc_out(pc_out), .link_addr(link_addr), .jump(jump),
        .branch(branch), .branchZero(branchZero), .regToPC(regToPC), .reg_a(reg_a), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    task automatic serve(input logic [0:31] word, input int wait_cycles, input logic [0:31] exp_addr);
        int n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_seen", 32'(imem_req), 32'd1);
        for (int i = 0; i < wait_cycles; i++) begin
            check("addr_wait", imem_addr, exp_addr);
            check("req_wait", 32'(imem_req), 32'd1);
            @(negedge clk);
        end
        check("addr", imem_addr, exp_addr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack = 1'b0;
        check("valid", 32'(inst_valid), 32'd1);
        check("inst", inst, word);
        check("pc_out", pc_out, exp_addr);
        check("link", link_addr, exp_addr + 32'd4);
    endtask

    task automatic retire(input logic j, input logic b, input logic bz, input logic r2pc, input logic [0:31] ra);
        inst_ready = 1'b1;
        jump = j; branch = b; branchZero = bz; regToPC = r2pc; reg_a = ra;
        @(negedge clk);
        inst_ready = 1'b0;
        jump = 1'b0; branch = 1'b0; branchZero = 1'b0; regToPC = 1'b0; reg_a = 32'hDEAD_BEEF;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'h100);
        check("rst_valid", 32'(inst_valid), 32'd0);
        check("rst_pc", pc_out, 32'h100);
        check("rst_link", link_addr, 32'h104);
        check("rst_inst", inst, 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        serve(32'h2001_0005, 0, 32'h100);
        retire(0, 0, 0, 0, 32'd0);
        serve(32'h0000_0000, 3, 32'h104);
        // branch cases from pc=0x200, reached through a JR
        retire(1, 0, 0, 1, 32'h200);
        serve(B_WORD, 0, 32'h200);
        retire(0, 1, 1, 0, 32'd0);
        serve(32'd0, 0, 32'h1FC);
        retire(1, 0, 0, 1, 32'h200);
        serve(B_WORD, 0, 32'h200);
        retire(0, 1, 1, 0, 32'd5);
        serve(32'd0, 0, 32'h204);
        retire(1, 0, 0, 1, 32'h200);
        serve(B_WORD, 0, 32'h200);
        retire(0, 1, 0, 0, 32'd5);
        serve(32'd0, 0, 32'h1FC);
        retire(1, 0, 0, 1, 32'h200);
        serve(B_WORD, 0, 32'h200);
        retire(1, 1, 0, 0, 32'd5);
        serve(32'd0, 0, 32'h101FC);
        retire(1, 0, 0, 1, 32'h400);
        serve(32'd0, 0, 32'h400);
        retire(1, 0, 0, 1, 32'h0);
        serve(J_WORD, 0, 32'h0);
        retire(1, 0, 0, 0, 32'd0);
        serve(32'h1234_5678, 0, 32'hFFFF_FFFC);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_inst", inst, 32'h1234_5678);
            check("bp_pc", pc_out, 32'hFFFF_FFFC);
            check("bp_req", 32'(imem_req), 32'd0);
            check("bp_valid", 32'(inst_valid), 32'd1);
        end
        imem_ack   = 1'b1;
        imem_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        imem_ack = 1'b0;
        check("spur_inst", inst, 32'h1234_5678);
        check("spur_valid", 32'(inst_valid), 32'd1);
        check("spur_req", 32'(imem_req), 32'd0);
        retire(1, 0, 0, 1, 32'h402);
`ifdef FETCH_MISALIGN_TRAP_EN
        for (int i = 0; i < 5; i++) begin
            check("trap_fault", 32'(fault), 32'd1);
            check("trap_req", 32'(imem_req), 32'd0);
            check("trap_valid", 32'(inst_valid), 32'd0);
            @(negedge clk);
        end
`else
        serve(32'd0, 0, 32'h400);
        retire(0, 0, 0, 0, 32'd0);
`endif
        reset = 1'b1;
        #1;
        check("arst_req", 32'(imem_req), 32'd0);
        check("arst_fault", 32'(fault), 32'd0);
        @(negedge clk);
        reset    = 1'b0;
        imem_ack = 1'b1;
        imem_rdata = 32'hBAD0_BAD0;
        @(negedge clk);
        imem_ack = 1'b0;
        check("idle_ack_valid", 32'(inst_valid), 32'd0);
        check("idle_ack_req", 32'(imem_req), 32'd1);
        serve(32'h0000_0001, 1, 32'h100);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1);
    end
endmodule
